// File: rtl/pipelined_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_shifter
//
// Pipelined barrel shifter: rotate left, shift left logical, shift right
// arithmetic and shift right logical of an N-bit operand by 0..N-1 bits.
// There is one pipeline stage per count bit; stage k applies the 2^k step
// when bit k of the transfer's count is set.  Valid/ready handshakes on both
// sides let the pipeline absorb backpressure: with the output stalled, bubbles
// are squeezed out until all C stages hold a transfer.
//
// Optional feature (macro SHIFTER_ZERO_FLAG_EN): adds port out_zero, a flag
// registered alongside the last stage that is set when the result is zero.
//
// Parameters:
//   N  operand width (power of two, 4..64)
//   C  count width, log2(N); also the number of pipeline stages
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operand/op/count presented
//   in_ready   block accepts input this cycle
//   in_data    operand
//   in_cnt     shift amount
//   in_op      00 rol, 01 sll, 10 sra, 11 srl
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_data   shifted result
//   out_zero   result is all zeros (SHIFTER_ZERO_FLAG_EN only)
// ----------------------------------------------------------------------------
module pipelined_shifter #(
   parameter int N = 16,
   parameter int C = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [C-1:0] in_cnt,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
`ifdef SHIFTER_ZERO_FLAG_EN
   ,
   output logic         out_zero
`endif
);

   // Single 2^k step for one stage.  Arithmetic right shift fills with the
   // MSB of the incoming stage data; earlier stages never alter that bit for
   // sra, so it is still the operand's original sign bit.
   function automatic logic [N-1:0] stage_shift(
      input logic [N-1:0] d,
      input logic [1:0]   op,
      input int           s
   );
      logic [N-1:0] r;
      case (op)
         2'b00:   r = (d << s) | (d >> (N - s));
         2'b01:   r = d << s;
         2'b10:   r = $signed(d) >>> s;
         2'b11:   r = d >> s;
         default: r = d;
      endcase
      return r;
   endfunction

   // stage registers
   logic [C-1:0] vld_r;
   logic [N-1:0] data_r [C];
   logic [1:0]   op_r   [C];
   logic [C-1:0] cnt_r  [C];
`ifdef SHIFTER_ZERO_FLAG_EN
   logic         zero_r;
`endif

   // per-stage load enable and next-state values
   logic [C-1:0] move_s;
   logic [C-1:0] src_vld_s;
   logic [N-1:0] src_data_s [C];
   logic [1:0]   src_op_s   [C];
   logic [C-1:0] src_cnt_s  [C];
   logic [N-1:0] nxt_data_s [C];

   // Stage k may load when it is empty or its successor can take its
   // content; unrolled, that is "out_ready, or some stage k..C-1 is empty".
   // Written in closed form so no combinational chain feeds itself.
   genvar g;
   generate
      for (g = 0; g < C; g++) begin : g_move
         assign move_s[g] = out_ready | ~(&vld_r[C-1:g]);
      end
   endgenerate

   // Select each stage's source (input port or previous stage) and apply
   // that stage's conditional 2^k step.
   always_comb begin
      src_vld_s[0]  = in_valid;
      src_data_s[0] = in_data;
      src_op_s[0]   = in_op;
      src_cnt_s[0]  = in_cnt;
      for (int k = 1; k < C; k++) begin
         src_vld_s[k]  = vld_r[k-1];
         src_data_s[k] = data_r[k-1];
         src_op_s[k]   = op_r[k-1];
         src_cnt_s[k]  = cnt_r[k-1];
      end
      for (int k = 0; k < C; k++) begin
         nxt_data_s[k] = src_cnt_s[k][k] ?
                         stage_shift(src_data_s[k], src_op_s[k], 1 << k) :
                         src_data_s[k];
      end
   end

   // Pipeline stage registers; a stage holds its content unless it moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < C; k++) begin
            vld_r[k]  <= 1'b0;
            data_r[k] <= {N{1'b0}};
            op_r[k]   <= 2'b00;
            cnt_r[k]  <= {C{1'b0}};
         end
      end else begin
         for (int k = 0; k < C; k++) begin
            if (move_s[k]) begin
               vld_r[k]  <= src_vld_s[k];
               data_r[k] <= nxt_data_s[k];
               op_r[k]   <= src_op_s[k];
               cnt_r[k]  <= src_cnt_s[k];
            end
         end
      end
   end

`ifdef SHIFTER_ZERO_FLAG_EN
   // Zero flag loads together with the last stage so it holds with out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_r <= 1'b0;
      end else if (move_s[C-1]) begin
         zero_r <= (nxt_data_s[C-1] == {N{1'b0}});
      end
   end

   assign out_zero = zero_r;
`endif

   // in_ready depends only on stage state and out_ready, never on in_valid.
   assign in_ready  = move_s[0];
   assign out_valid = vld_r[C-1];
   assign out_data  = data_r[C-1];

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter. Supports rotate left, shift left logical, shift right arithmetic and shift right logical on an N-bit operand, by 0 to N-1 bits.
- One pipeline stage per count bit; stage k applies the 2^k shift.
- Valid/ready handshakes on input and output, so the block sits between the decode/issue logic and the ALU writeback path and absorbs backpressure.

Parameters:
- N, 16, operand width. Power of two, 4..64.
- C, 4, count width. Must equal log2(N); also the number of pipeline stages.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand/op/count presented
- in_ready  output  1  block accepts input this cycle
- in_data  input  N  operand
- in_cnt  input  C  shift amount
- in_op  input  2  00 rotate left, 01 shift left, 10 shift right arithmetic, 11 shift right logical
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  N  shifted result
- out_zero  output  1  result is all zeros (present only with the optional feature)

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset: all stage valid bits clear. out_valid=0, in_ready=1, out_data=0, out_zero=0.
- Stage registers: each of the C stages holds valid, data[N-1:0], op[1:0] and cnt[C-1:0].
- Stage k function: if cnt[k]=1, shift data by 2^k according to op, otherwise pass data through.
  - Rotate: bits leaving the MSB enter the LSB.
  - Shift left logical: zero fill at the LSB.
  - Shift right arithmetic: fill with the original data[N-1]. This is the sign bit of the incoming stage data, which is preserved through the earlier stages.
  - Shift right logical: zero fill at the MSB.
- Stage 0 loads from in_* on acceptance. Stage k>0 loads from stage k-1.
- Advance rule: stage k advances when its successor is empty or the successor itself advances. The last stage advances when out_ready=1.
  - in_ready = !stage0.valid || stage0 advances. Combinational, with no path from in_valid.
  - out_valid = stage[C-1].valid. out_data = stage[C-1].data.
- Latency: a transfer accepted in cycle t shows out_valid in cycle t+C, provided there is no backpressure.
- Throughput: one result per cycle sustained while out_ready=1.
- Backpressure:
  - With out_ready=0, the pipeline compresses: bubbles are squeezed out and up to C transfers are held.
  - Once all stages are full, in_ready=0.
  - No transfer is dropped, duplicated or reordered.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_zero and out_valid hold stable.
- Count handling: cnt=0 passes data unchanged for every op. Counts wrap naturally at C bits; there are no illegal counts.
- Simultaneous events: in the same cycle as the last stage drains, a new input is accepted into stage 0 with no bubble.
- Reset mid-operation: rst during a non-empty pipeline discards all in-flight transfers. The next cycle shows out_valid=0 and in_ready=1.
- Input stability: when in_valid=1 and in_ready=0, the producer holds in_* stable. The block does not latch them early.

Optional Feature:
- Macro: SHIFTER_ZERO_FLAG_EN.
- Defined: port out_zero exists.
  - It is registered alongside stage C-1 data and equals (data == 0) of the final result.
  - It follows the same stability rule as out_data and resets to 0.
- Undefined: port out_zero and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic ops, N=16, issued back-to-back, out_ready=1:
  - rol 0x8001 by 1 -> 0x0003
  - sll 0x00FF by 4 -> 0x0FF0
  - sra 0x8000 by 15 -> 0xFFFF
  - srl 0x8000 by 15 -> 0x0001
  - Required response: results appear in cycles t+4..t+7, in order.
- Zero count: each op with cnt=0 on 0xA5C3 -> 0xA5C3 for all four ops. Rotate by 8 on 0x12AB -> 0xAB12.
- Backpressure:
  - Hold out_ready=0 and offer 6 inputs.
  - Required: exactly 4 are accepted, then in_ready=0, with out_data held at the first result.
  - Release out_ready: all 6 results emerge in order with no gaps after the first.
- Reset mid-flight:
  - With 3 transfers in flight, assert rst for one cycle.
  - Required: out_valid=0 and in_ready=1 the next cycle; no stale result ever appears.
- Zero flag (SHIFTER_ZERO_FLAG_EN defined):
  - sll 0x0001 by 15 -> 0x8000 with out_zero=0.
  - srl 0x0001 by 1 -> 0x0000 with out_zero=1.
  - Undefined build: compiles, and the basic-ops results are unchanged.
